instr_fetch_buffer: RTL
=======================

Name: instr_fetch_buffer

Overview:
- Small first-word-fall-through instruction queue between instruction memory/cache return path and the decode stage.
- Decouples fetch latency from decode stalls.
- Presents the head instruction, its PC and pre-split opcode/func3/func7[5] fields directly to the decode-stage control logic.
- Flushes on taken branch/jump redirect.

Parameters:
- DEPTH, 4, number of instruction entries; power of two, >= 2.
- XLEN, 64, PC width in bits.
- NOP_INSTR, 32'h0000_0013, value driven on instruction outputs when empty (addi x0,x0,0).

Ports:
- i_clk  input  1  core clock; all state updates on rising edge.
- i_arstn  input  1  asynchronous active-low reset.
- i_fetch_valid  input  1  fetch side presents a valid instruction this cycle.
- i_fetch_instr  input  32  fetched instruction word.
- i_fetch_pc  input  XLEN  PC of i_fetch_instr.
- o_fetch_ready  output  1  buffer can accept a word this cycle.
- i_dec_ready  input  1  decode consumes head this cycle (not stalled).
- o_dec_valid  output  1  head entry valid.
- o_dec_instr  output  32  head instruction, or NOP_INSTR when invalid.
- o_dec_pc  output  XLEN  head PC, or 0 when invalid.
- o_op  output  7  o_dec_instr[6:0].
- o_func3  output  3  o_dec_instr[14:12].
- o_func7_5  output  1  o_dec_instr[30].
- i_flush  input  1  redirect: discard all entries.
- o_count  output  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Reset (i_arstn=0, asynchronous):
  - read/write pointers = 0, count = 0.
  - o_dec_valid = 0, o_dec_instr = NOP_INSTR, o_dec_pc = 0, o_fetch_ready = 1, o_count = 0.
  - Storage contents don't care.
- Reset release mid-operation: all in-flight entries are lost; buffer restarts empty.
- Push: occurs when i_fetch_valid & o_fetch_ready & !i_flush.
  - Writes {instr, pc} at the write pointer.
  - Write pointer increments modulo DEPTH.
- Pop: occurs when o_dec_valid & i_dec_ready.
  - Read pointer increments modulo DEPTH.
- o_fetch_ready = (count < DEPTH), registered state only; there is no combinational path from i_dec_ready or i_flush.
- o_dec_valid = (count != 0) & !i_flush.
- Head outputs are combinational reads of the entry at the read pointer, gated to NOP_INSTR/0 when o_dec_valid = 0.
- o_op, o_func3 and o_func7_5 are always slices of the gated o_dec_instr. When empty they therefore decode as OP-IMM/addi: 7'b0010011, 3'b000, 0.
- Latency: a word pushed in cycle N is visible at the head no earlier than cycle N+1. There is no same-cycle bypass, including when the buffer is empty.
- Count update, when not flushing: count_next = count + push - pop.
  - Simultaneous push and pop leaves count unchanged; both pointers advance.
- Full (count == DEPTH):
  - o_fetch_ready = 0 and the fetch word is not accepted, even if a pop occurs the same cycle.
  - A pop in the full cycle makes o_fetch_ready = 1 in the next cycle.
- Empty (count == 0): pop cannot occur, because o_dec_valid = 0.
- Flush (i_flush = 1), synchronous:
  - Next cycle: count = 0 and both pointers = 0.
  - Any push in the flush cycle is dropped.
  - No pop occurs in the flush cycle; o_dec_valid is already 0 in it.
  - Flush has priority over push and pop.
- Pointer wrap: after DEPTH pushes the write pointer returns to 0. FIFO ordering is preserved across the wrap.
- Ordering: entries emerge strictly in push order. Each instruction's PC stays paired with it.

Test Plan:
- Reset then idle:
  - Assert i_arstn=0 mid-cycle -> outputs go to reset values immediately: o_dec_valid=0, o_op=7'h13, o_count=0, o_fetch_ready=1.
- Fill to full with decode stalled (i_dec_ready=0):
  - Push 0x00500093@pc 0x0, 0x00A00113@0x4, 0x002081B3@0x8, 0x40208233@0xC.
  - Expect o_count=4 and o_fetch_ready=0.
  - A fifth push (0x00000013@0x10) is not accepted.
  - Head shows 0x00500093, pc 0x0, o_op=7'h13, o_func3=0.
- Drain in order:
  - From full, hold i_dec_ready=1 for 4 cycles -> heads appear in push order.
  - At 0x40208233: o_op=7'h33, o_func7_5=1.
  - Then o_dec_valid=0 and o_dec_instr=NOP_INSTR.
- Streaming with wrap:
  - Push and pop every cycle for 10 cycles after one preload (PCs 0x100 step 4).
  - o_count stays 1; PCs emerge contiguous 0x100..0x124 across pointer wrap.
- Flush with simultaneous push:
  - With 3 entries, assert i_flush with i_fetch_valid=1 (0x0000006F@0x200).
  - o_dec_valid=0 in that cycle; next cycle o_count=0.
  - 0x0000006F is never presented.
  - The next push after flush appears at the head one cycle later.
- Empty push latency:
  - From empty, push 0x00002003@0x40 with i_dec_ready=1.
  - Same cycle: o_dec_valid=0.
  - Next cycle: valid with o_op=7'h03, o_func3=3'b010; it pops then, and o_count returns to 0.

Source files
------------

// File: rtl/instr_fetch_buffer.sv
// ---------------------------------------------------------------------------
// instr_fetch_buffer
//
// Purpose:
//   Small first-word-fall-through instruction queue that sits between the
//   instruction memory/cache return path and the decode stage. It lets fetch
//   keep running while decode is stalled. It presents the head instruction,
//   its PC and the pre-split opcode/func3/func7[5] fields to the decode
//   control logic. A taken branch/jump redirect (i_flush) empties the queue.
//
// Ports:
//   i_clk          core clock, rising edge
//   i_arstn        asynchronous active-low reset
//   i_fetch_valid  fetch presents a word this cycle
//   i_fetch_instr  fetched instruction word
//   i_fetch_pc     PC of i_fetch_instr
//   o_fetch_ready  buffer can accept a word (depends on registered state only)
//   i_dec_ready    decode consumes the head this cycle
//   o_dec_valid    head entry valid
//   o_dec_instr    head instruction, NOP_INSTR when not valid
//   o_dec_pc       head PC, 0 when not valid
//   o_op           o_dec_instr[6:0]
//   o_func3        o_dec_instr[14:12]
//   o_func7_5      o_dec_instr[30]
//   i_flush        redirect: discard every entry
//   o_count        number of valid entries
// ---------------------------------------------------------------------------
module instr_fetch_buffer #(
   parameter int          DEPTH     = 4,
   parameter int          XLEN      = 64,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                       i_clk,
   input  logic                       i_arstn,
   input  logic                       i_fetch_valid,
   input  logic [31:0]                i_fetch_instr,
   input  logic [XLEN-1:0]            i_fetch_pc,
   output logic                       o_fetch_ready,
   input  logic                       i_dec_ready,
   output logic                       o_dec_valid,
   output logic [31:0]                o_dec_instr,
   output logic [XLEN-1:0]            o_dec_pc,
   output logic [6:0]                 o_op,
   output logic [2:0]                 o_func3,
   output logic                       o_func7_5,
   input  logic                       i_flush,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);
   localparam logic [CW-1:0] CNT_ZERO   = CW'(1'b0);
   localparam logic [CW-1:0] CNT_DEPTH  = CW'(DEPTH);

   logic [31:0]     instr_mem_q [DEPTH];
   logic [31:0]     instr_mem_d [DEPTH];
   logic [XLEN-1:0] pc_mem_q    [DEPTH];
   logic [XLEN-1:0] pc_mem_d    [DEPTH];

   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q,  count_d;

   logic            fetch_ready_s;
   logic            dec_valid_s;
   logic            push_s;
   logic            pop_s;

   // Handshake qualifiers. Ready comes from the registered count alone, so a
   // full buffer refuses a word even when decode pops in the same cycle.
   always_comb begin
      fetch_ready_s = (count_q != CNT_DEPTH);
      dec_valid_s   = (count_q != CNT_ZERO) & ~i_flush;
      push_s        = i_fetch_valid & fetch_ready_s & ~i_flush;
      pop_s         = dec_valid_s & i_dec_ready;
   end

   // Next-state for pointers, count and storage; flush overrides push and pop.
   always_comb begin
      instr_mem_d = instr_mem_q;
      pc_mem_d    = pc_mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (i_flush) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         count_d  = CNT_ZERO;
      end else begin
         if (push_s) begin
            instr_mem_d[wr_ptr_q] = i_fetch_instr;
            pc_mem_d[wr_ptr_q]    = i_fetch_pc;
            // DEPTH is a power of two, so natural overflow wraps modulo DEPTH
            wr_ptr_d              = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         count_d = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
      end
   end

   // Control state: pointers and occupancy, cleared asynchronously.
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= CNT_ZERO;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are only observed while count marks them valid,
   // so it carries no reset.
   always_ff @(posedge i_clk) begin
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
   end

   // Head presentation: combinational read gated to a NOP when nothing valid.
   // There is no bypass, so a word written this cycle shows up next cycle.
   always_comb begin
      o_fetch_ready = fetch_ready_s;
      o_dec_valid   = dec_valid_s;
      o_count       = count_q;
      if (dec_valid_s) begin
         o_dec_instr = instr_mem_q[rd_ptr_q];
         o_dec_pc    = pc_mem_q[rd_ptr_q];
      end else begin
         o_dec_instr = NOP_INSTR;
         o_dec_pc    = {XLEN{1'b0}};
      end
      o_op      = o_dec_instr[6:0];
      o_func3   = o_dec_instr[14:12];
      o_func7_5 = o_dec_instr[30];
   end

endmodule
